// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link (receiver and transmitter).
package serial_pkg;

    localparam int unsigned MAX_DATA_W = 16;

    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic STOP_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4
    } rx_state_t;

    // Even-parity check: 1 when the data bits plus the parity bit hold an odd number of ones.
    function automatic logic parity_mismatch(input logic [MAX_DATA_W-1:0] bits, input logic pbit);
        return (^bits) ^ pbit;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for an asynchronous single-bit input; flops reset to 1 (idle line).
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/serial_rx_deser.sv
// Serial frame receiver: start/data/optional even parity/stop on a bit-rate tick,
// reassembled into DATA_W-bit words with one-cycle valid and error pulses.
module serial_rx_deser
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned PARITY_EN   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rxd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    rx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic [CNT_W-1:0]  cnt;
    logic              perr;
    logic              rxs;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rxd),
        .q    (rxs)
    );

    // New bit enters at the MSB so the first data bit ends up in the LSB.
    assign shreg_next = (shreg >> 1) | (DATA_W'(rxs) << (DATA_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            perr       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (rxs != IDLE_LEVEL) begin
                            state <= DATA;
                            shreg <= '0;
                            cnt   <= '0;
                            perr  <= 1'b0;
                        end
                    end
                    DATA: begin
                        shreg <= shreg_next;
                        if (cnt != CNT_W'(DATA_W)) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        perr  <= parity_mismatch(MAX_DATA_W'(shreg), rxs);
                        state <= STOP;
                    end
                    STOP: begin
                        if (rxs == STOP_LEVEL) begin
                            rx_data    <= shreg;
                            rx_valid   <= 1'b1;
                            parity_err <= perr;
                            state      <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                    BREAK: begin
                        // A held-low line after a bad frame must not be taken as a start bit.
                        if (rxs == IDLE_LEVEL) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
